// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared types and defaults for the round-robin mux arbiter
package mux_arb_pkg;

   // Arbiter FSM: IDLE picks a winner, HOLD presents the captured word until consumed
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_N     = 8;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester pool / consumer bundle for the round-robin mux arbiter
interface mux_rr_arbiter_if
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = DEF_N
);
   localparam int SEL_W = $clog2(N);

   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] din;
   logic [N-1:0]       gnt;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SEL_W-1:0]   out_sel;
   logic               busy;

   // Requesters and consumer side
   modport master (
      output req, din, out_ready,
      input  gnt, out_valid, out_data, out_sel, busy
   );

   // Arbiter side
   modport slave (
      input  req, din, out_ready,
      output gnt, out_valid, out_data, out_sel, busy
   );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rtl/mux_rr_arbiter_rr_pick.sv - rotated priority scan starting at the round-robin pointer
module rr_pick #(
   parameter int N     = 8,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   int               w_pos;
   logic [SEL_W-1:0] w_pos_idx;
   logic             w_found;

   // First set request at ptr, ptr+1, ... with explicit wrap at N so odd N never overflows
   always_comb begin
      idx       = '0;
      w_found   = 1'b0;
      w_pos     = 0;
      w_pos_idx = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = int'(ptr) + k;
         if (w_pos >= N) begin
            w_pos = w_pos - N;
         end
         w_pos_idx = SEL_W'(w_pos);
         if (!w_found && req[w_pos_idx]) begin
            w_found = 1'b1;
            idx     = w_pos_idx;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin N-to-1 mux scheduler with registered valid/ready output
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = DEF_N
) (
   input  logic            clk,
   input  logic            rst_n,
   mux_rr_arbiter_if.slave bus
);

   localparam int               SEL_W = $clog2(N);
   localparam logic [SEL_W-1:0] LAST  = SEL_W'(N-1);

   arb_state_t       r_state;
   arb_state_t       w_next_state;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] r_out_sel;
   logic [WIDTH-1:0] r_out_data;

   logic             w_any;
   logic [SEL_W-1:0] w_idx;
   logic [WIDTH-1:0] w_din [N];
   logic [N-1:0]     w_gnt;
   logic             w_hold;
   logic             w_handshake;

   rr_pick #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .req (bus.req),
      .ptr (r_ptr),
      .any (w_any),
      .idx (w_idx)
   );

   // Unpack the flat data bus so the winner can be selected by index
   always_comb begin
      for (int i = 0; i < N; i++) begin
         w_din[i] = bus.din[i*WIDTH +: WIDTH];
      end
   end

   assign w_hold      = (r_state == HOLD);
   assign w_handshake = w_hold & bus.out_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: capture on any request, release on handshake (forces one IDLE bubble)
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_any)        w_next_state = HOLD;
         HOLD:    if (bus.out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Capture winner in IDLE; advance pointer past the served requester on handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_out_sel  <= '0;
         r_out_data <= '0;
      end else if (!w_hold) begin
         if (w_any) begin
            r_out_sel  <= w_idx;
            r_out_data <= w_din[w_idx];
         end
      end else if (bus.out_ready) begin
         r_ptr <= (r_out_sel == LAST) ? '0 : r_out_sel + 1'b1;
      end
   end

   // One-hot acknowledge to the served requester on the consuming cycle
   always_comb begin
      w_gnt = '0;
      if (w_handshake) begin
         w_gnt[r_out_sel] = 1'b1;
      end
   end

   assign bus.gnt       = w_gnt;
   assign bus.out_valid = w_hold;
   assign bus.busy      = w_hold;
   assign bus.out_sel   = r_out_sel;
   assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for the round-robin mux arbiter
module tb_mux_rr_arbiter;

   typedef struct packed {
      logic [2:0] sel;
      logic [7:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   exp_t sb [$];
   exp_t m_exp;
   logic [7:0] m_gnt;

   mux_rr_arbiter_if #(.WIDTH(8), .N(8)) bus ();

   mux_rr_arbiter #(.WIDTH(8), .N(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every consumed word must match the head of the scoreboard; gnt idle otherwise
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_grant: out_sel=%0d out_data=%h, no grant expected", bus.out_sel, bus.out_data);
         end else begin
            n_pass++;
            m_exp = sb.pop_front();
            m_gnt = 8'b1 << m_exp.sel;
            n_checks++;
            if (bus.out_sel !== m_exp.sel) $display("FAIL sb_sel: got %0d, required %0d", bus.out_sel, m_exp.sel);
            else n_pass++;
            n_checks++;
            if (bus.out_data !== m_exp.data) $display("FAIL sb_data: got %h, required %h", bus.out_data, m_exp.data);
            else n_pass++;
            n_checks++;
            if (bus.gnt !== m_gnt) $display("FAIL sb_gnt: got %b, required %b", bus.gnt, m_gnt);
            else n_pass++;
         end
      end else begin
         n_checks++;
         if (bus.gnt !== 8'h00) $display("FAIL gnt_idle: got %b, required 00000000", bus.gnt);
         else n_pass++;
      end
   end

   task automatic apply_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", bus.busy); else n_pass++;
      n_checks++; if (bus.out_sel !== 3'd0) $display("FAIL rst_sel: got %0d, required 0", bus.out_sel); else n_pass++;
      n_checks++; if (bus.out_data !== 8'h00) $display("FAIL rst_data: got %h, required 00", bus.out_data); else n_pass++;
      n_checks++; if (bus.gnt !== 8'h00) $display("FAIL rst_gnt: got %b, required 0", bus.gnt); else n_pass++;
      sb.push_back('{sel: 3'd0, data: 8'hC0});
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL rst_first_valid: got %b, required 1", bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_sel !== 3'd0) $display("FAIL rst_first_sel: got %0d, required 0", bus.out_sel); else n_pass++;
      n_checks++; if (bus.out_data !== 8'hC0) $display("FAIL rst_first_data: got %h, required c0", bus.out_data); else n_pass++;
      @(posedge clk); #1 bus.out_ready = 1'b1;
      for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
      bus.req = '0;
      n_checks++;
      if (sb.size() != 0) begin $display("FAIL rst_drain: %0d outstanding, required 0", sb.size()); sb.delete(); end
      else n_pass++;
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      bus.req = 8'b0010_0000;
      bus.din[5*8 +: 8] = 8'hA5;
      bus.out_ready = 1'b1;
      sb.push_back('{sel: 3'd5, data: 8'hA5});
      sb.push_back('{sel: 3'd5, data: 8'hA5});
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_latency: got %b, required 1", bus.out_valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_bubble: got %b, required 0", bus.out_valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_regrant: got %b, required 1", bus.out_valid); else n_pass++;
      for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
      bus.req = '0;
      n_checks++;
      if (sb.size() != 0) begin $display("FAIL single_drain: %0d outstanding, required 0", sb.size()); sb.delete(); end
      else n_pass++;
   endtask

   task automatic test_fairness();
      int last;
      int ngr;
      apply_reset();
      for (int i = 0; i < 8; i++) bus.din[i*8 +: 8] = 8'hC0 + 8'(i);
      for (int i = 0; i < 10; i++) sb.push_back('{sel: 3'(i % 8), data: 8'hC0 + 8'(i % 8)});
      bus.out_ready = 1'b1;
      bus.req = 8'hFF;
      last = -1;
      ngr = 0;
      for (int cyc = 0; cyc < 60 && ngr < 10; cyc++) begin
         @(negedge clk);
         if (bus.gnt !== 8'h00) begin
            if (ngr > 0) begin
               n_checks++;
               if (cyc - last != 2) $display("FAIL fair_spacing: got %0d cycles, required 2", cyc - last);
               else n_pass++;
            end
            last = cyc;
            ngr++;
         end
      end
      bus.req = '0;
      n_checks++; if (ngr != 10) $display("FAIL fair_count: got %0d grants, required 10", ngr); else n_pass++;
      for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin $display("FAIL fair_drain: %0d outstanding, required 0", sb.size()); sb.delete(); end
      else n_pass++;
   endtask

   task automatic test_backpressure();
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.req = 8'b0000_1000;
      bus.din[3*8 +: 8] = 8'h3C;
      sb.push_back('{sel: 3'd3, data: 8'h3C});
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid: got %b, required 1", bus.out_valid); else n_pass++;
         n_checks++; if (bus.out_data !== 8'h3C) $display("FAIL bp_data: got %h, required 3c", bus.out_data); else n_pass++;
         n_checks++; if (bus.out_sel !== 3'd3) $display("FAIL bp_sel: got %0d, required 3", bus.out_sel); else n_pass++;
         bus.din[3*8 +: 8] = 8'hFF;
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.req = '0;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_idle: got %b, required 0", bus.out_valid); else n_pass++;
      n_checks++;
      if (sb.size() != 0) begin $display("FAIL bp_drain: %0d outstanding, required 0", sb.size()); sb.delete(); end
      else n_pass++;
   endtask

   task automatic test_wrap();
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.req = 8'b0010_0000;
      bus.din[5*8 +: 8] = 8'h55;
      bus.din[0*8 +: 8] = 8'hA0;
      bus.din[1*8 +: 8] = 8'hA1;
      sb.push_back('{sel: 3'd5, data: 8'h55});
      sb.push_back('{sel: 3'd0, data: 8'hA0});
      sb.push_back('{sel: 3'd1, data: 8'hA1});
      @(posedge clk); #1;
      bus.req = 8'b0000_0011;
      for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
      bus.req = '0;
      n_checks++;
      if (sb.size() != 0) begin $display("FAIL wrap_drain: %0d outstanding, required 0", sb.size()); sb.delete(); end
      else n_pass++;
   endtask

   task automatic test_reset_mid_hold();
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.req = 8'b0001_0000;
      bus.din[4*8 +: 8] = 8'h44;
      bus.din[0*8 +: 8] = 8'h0A;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.out_sel !== 3'd4) $display("FAIL mid_hold_sel: got %0d, required 4", bus.out_sel); else n_pass++;
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b, required 0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy: got %b, required 0", bus.busy); else n_pass++;
      n_checks++; if (bus.gnt !== 8'h00) $display("FAIL mid_rst_gnt: got %b, required 0", bus.gnt); else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.req = 8'b0001_0001;
      bus.out_ready = 1'b1;
      sb.push_back('{sel: 3'd0, data: 8'h0A});
      for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clk);
      bus.req = '0;
      n_checks++;
      if (sb.size() != 0) begin $display("FAIL mid_rst_drain: %0d outstanding, required 0", sb.size()); sb.delete(); end
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      rst_n = 1'b0;
      bus.req = 8'hFF;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) bus.din[i*8 +: 8] = 8'hC0 + 8'(i);
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_wrap();
      test_reset_mid_hold();
      repeat (4) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) $display("FAIL final_sb: %0d outstanding, required 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
